// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer: assembles WIDTH bits (MSB first) into a word
// and presents it on a valid/ready port backed by a one-word holding buffer.
// A completed word arriving while the buffer is full and not being consumed is
// dropped and recorded in a sticky overrun flag.
module serial_deser #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_en,
    input  logic             frame_start,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun,
    input  logic             clr_overrun
);

    typedef enum logic {
        StEmpty,
        StFull
    } buf_state_e;

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] word_q;
    logic             ovr_q;
    buf_state_e       state_q;

    logic             complete;
    logic [WIDTH-1:0] word_new;

    // A frame_start on the last bit cancels the completion and restarts alignment.
    always_comb begin
        complete = ser_en && !frame_start && (cnt_q == LastIdx);
        word_new = {shreg_q[WIDTH-2:0], ser_in};
    end

    // Shift register and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (ser_en) begin
            if (frame_start) begin
                shreg_q <= {{(WIDTH-1){1'b0}}, ser_in};
                cnt_q   <= CNT_W'(1);
            end else begin
                shreg_q <= word_new;
                cnt_q   <= complete ? '0 : cnt_q + CNT_W'(1);
            end
        end else if (frame_start) begin
            cnt_q <= '0;
        end
    end

    // Output holding buffer FSM with sticky overrun; overrun set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            word_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (complete) begin
                        word_q  <= word_new;
                        state_q <= StFull;
                    end
                end
                StFull: begin
                    if (complete && par_ready) begin
                        word_q <= word_new;
                    end else if (par_ready) begin
                        state_q <= StEmpty;
                    end
                end
                default: state_q <= StEmpty;
            endcase

            if (complete && (state_q == StFull) && !par_ready) begin
                ovr_q <= 1'b1;
            end else if (clr_overrun) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign par_out   = word_q;
    assign par_valid = (state_q == StFull);
    assign bit_cnt   = cnt_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_deser.sv
// Self-checking bench for serial_deser: table-driven word vectors, directed
// corner-case sequences and randomized traffic against a behavioural model.
module tb_serial_deser;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst, ser_in, ser_en, frame_start, par_ready, clr_overrun;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;

    always #5 clk = ~clk;

    serial_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_in     (ser_in),
        .ser_en     (ser_en),
        .frame_start(frame_start),
        .par_out    (par_out),
        .par_valid  (par_valid),
        .par_ready  (par_ready),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: bit count within the current word, the value of the
    // bits gathered so far, and the contents of the one-word output buffer.
    int          m_cnt  = 0;
    logic [31:0] m_acc  = '0;
    logic [31:0] m_word = '0;
    bit          m_full = 1'b0;
    bit          m_ovr  = 1'b0;

    typedef struct {
        logic [31:0] word;
        bit          drain;
        bit          rdy_body;
        bit          rdy_last;
        logic [31:0] exp_out;
        bit          exp_valid;
        bit          exp_ovr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_step(input bit r, input bit s, input bit e, input bit f,
                              input bit rdy, input bit c);
        bit          comp;
        logic [31:0] cw;
        if (r) begin
            m_cnt = 0; m_acc = '0; m_word = '0; m_full = 0; m_ovr = 0;
            return;
        end
        comp = e && !f && (m_cnt == WIDTH - 1);
        cw   = m_acc * 2 + 32'(s);
        if (comp && m_full && !rdy) m_ovr = 1;
        else if (c) m_ovr = 0;
        if (comp) begin
            if (!m_full || rdy) begin
                m_word = cw;
                m_full = 1;
            end
        end else if (m_full && rdy) begin
            m_full = 0;
        end
        if (e) begin
            if (f) begin
                m_acc = 32'(s);
                m_cnt = 1;
            end else if (comp) begin
                m_cnt = 0;
            end else begin
                m_acc = cw;
                m_cnt++;
            end
        end else if (f) begin
            m_cnt = 0;
        end
    endtask

    // One clock: apply inputs, advance model at the edge, compare 1 time unit later.
    task automatic drive(input bit r, input bit s, input bit e, input bit f,
                         input bit rdy, input bit c);
        rst = r; ser_in = s; ser_en = e; frame_start = f; par_ready = rdy; clr_overrun = c;
        @(posedge clk);
        model_step(r, s, e, f, rdy, c);
        #1;
        check("model_par_out", 64'(par_out), 64'(m_word));
        check("model_par_valid", 64'(par_valid), 64'(m_full));
        check("model_bit_cnt", 64'(bit_cnt), 64'(m_cnt));
        check("model_overrun", 64'(overrun), 64'(m_ovr));
    endtask

    task automatic shift_word(input logic [31:0] w, input bit rdy_body, input bit rdy_last);
        for (int i = WIDTH - 1; i >= 0; i--)
            drive(0, w[i], 1, 0, (i == 0) ? rdy_last : rdy_body, 0);
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 1, 1);
    endtask

    task automatic apply_vec(input int i);
        if (vecs[i].drain) begin
            drain();
            check($sformatf("vec%0d_drain_valid", i), 64'(par_valid), 64'd0);
        end
        shift_word(vecs[i].word, vecs[i].rdy_body, vecs[i].rdy_last);
        check($sformatf("vec%0d_par_out", i), 64'(par_out), 64'(vecs[i].exp_out));
        check($sformatf("vec%0d_par_valid", i), 64'(par_valid), 64'(vecs[i].exp_valid));
        check($sformatf("vec%0d_overrun", i), 64'(overrun), 64'(vecs[i].exp_ovr));
        check($sformatf("vec%0d_bit_cnt", i), 64'(bit_cnt), 64'd0);
    endtask

    initial begin
        logic [31:0] junk;
        bit          r, f, e, rdy, c;

        vecs[0] = '{32'hA5A5_3C3C, 1, 1, 1, 32'hA5A5_3C3C, 1, 0};
        vecs[1] = '{32'h0000_0001, 1, 1, 1, 32'h0000_0001, 1, 0};
        vecs[2] = '{32'hFFFF_FFFE, 0, 1, 1, 32'hFFFF_FFFE, 1, 0};
        vecs[3] = '{32'h1234_5678, 1, 0, 0, 32'h1234_5678, 1, 0};
        vecs[4] = '{32'hDEAD_BEEF, 0, 0, 0, 32'h1234_5678, 1, 1};
        vecs[5] = '{32'h1111_1111, 1, 0, 0, 32'h1111_1111, 1, 0};
        vecs[6] = '{32'h2222_2222, 0, 0, 1, 32'h2222_2222, 1, 0};

        rst = 1; ser_in = 0; ser_en = 0; frame_start = 0; par_ready = 0; clr_overrun = 0;

        // Reset state.
        drive(1, 0, 0, 0, 0, 0);
        check("reset_par_out", 64'(par_out), 64'd0);
        check("reset_par_valid", 64'(par_valid), 64'd0);
        check("reset_bit_cnt", 64'(bit_cnt), 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);

        apply_vec(0);
        // Consumed on the next ready cycle: valid for exactly one cycle.
        drive(0, 0, 0, 0, 1, 0);
        check("single_valid_pulse", 64'(par_valid), 64'd0);
        check("retain_par_out", 64'(par_out), 64'hA5A5_3C3C);

        for (int i = 0; i < 5; i++) if (i > 0) apply_vec(i);

        // Clearing the sticky overrun.
        drive(0, 0, 0, 0, 0, 1);
        check("clr_overrun", 64'(overrun), 64'd0);
        check("clr_keeps_word", 64'(par_out), 64'h1234_5678);

        for (int i = 5; i < 7; i++) apply_vec(i);

        // frame_start realigns mid-word.
        drain();
        junk = $urandom;
        for (int i = 0; i < 10; i++) drive(0, junk[i], 1, 0, 1, 0);
        drive(0, 1'b1, 1, 1, 1, 0);
        check("fs_bit_cnt", 64'(bit_cnt), 64'd1);
        junk = 32'hCAFE_F00D;
        for (int i = WIDTH - 2; i >= 0; i--) drive(0, junk[i], 1, 0, 1, 0);
        check("fs_par_out", 64'(par_out), 64'hCAFE_F00D);
        check("fs_par_valid", 64'(par_valid), 64'd1);

        // frame_start on the completing bit cancels the completion.
        drain();
        junk = $urandom;
        for (int i = 0; i < WIDTH - 1; i++) drive(0, junk[i], 1, 0, 1, 0);
        check("pre_cancel_cnt", 64'(bit_cnt), 64'd31);
        drive(0, 1, 1, 1, 1, 0);
        check("cancel_bit_cnt", 64'(bit_cnt), 64'd1);
        check("cancel_no_valid", 64'(par_valid), 64'd0);
        drive(0, 0, 0, 1, 1, 0);
        check("fs_noen_cnt", 64'(bit_cnt), 64'd0);

        // Reset mid-word while a word is held.
        drain();
        shift_word(32'h0F0F_0F0F, 0, 0);
        junk = $urandom;
        for (int i = 0; i < 17; i++) drive(0, junk[i], 1, 0, 0, 0);
        check("mid_cnt", 64'(bit_cnt), 64'd17);
        check("mid_valid", 64'(par_valid), 64'd1);
        drive(1, 1, 1, 1, 1, 0);
        check("rst_bit_cnt", 64'(bit_cnt), 64'd0);
        check("rst_par_valid", 64'(par_valid), 64'd0);
        check("rst_par_out", 64'(par_out), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        shift_word(32'h5A5A_C3C3, 1, 1);
        check("post_rst_word", 64'(par_out), 64'h5A5A_C3C3);
        check("post_rst_valid", 64'(par_valid), 64'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            r   = ($urandom_range(0, 299) == 0);
            f   = ($urandom_range(0, 59) == 0);
            e   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            c   = ($urandom_range(0, 49) == 0);
            drive(r, 1'($urandom), e, f, rdy, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_deser.md
Name: serial_deser

Overview:
- Serial-to-parallel deserializer: the receive end of the bit-serial link fed by the pipeline's parallel-in/serial-out shift register.
- Collects WIDTH serial bits, MSB first, into a word.
- Presents each word on a valid/ready output port with a one-word holding buffer.
- Flags overruns when a completed word cannot be stored.

Parameters:
WIDTH, 32, bits per assembled word (minimum 2)
CNT_W, 5, width of bit counter; must satisfy 2**CNT_W >= WIDTH

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
ser_in  input  1  serial data bit, MSB of word first
ser_en  input  1  ser_in valid this cycle; bit sampled only when high
frame_start  input  1  word alignment; marks ser_in as bit WIDTH-1 of a new word
par_out  output  WIDTH  assembled word; stable while par_valid high
par_valid  output  1  par_out holds an unconsumed word
par_ready  input  1  consumer accepts par_out when par_valid && par_ready
bit_cnt  output  CNT_W  number of bits collected into current partial word
overrun  output  1  sticky: a completed word was dropped
clr_overrun  input  1  clears overrun

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset (rst=1 at a clock edge) sets the following; rst dominates all other inputs:
  - shift reg = 0, bit_cnt = 0, par_out = 0
  - par_valid = 0, overrun = 0
- Shift (ser_en=1): shreg <= {shreg[WIDTH-2:0], ser_in}; bit_cnt increments.
  - ser_en=0: shreg and bit_cnt hold.
- frame_start:
  - With ser_en=1: partial word discarded; ser_in becomes first bit; bit_cnt <= 1.
  - With ser_en=0: bit_cnt <= 0.
  - frame_start on a completing bit: the completion is cancelled; the bit starts a new word.
- Word completion: ser_en=1, bit_cnt==WIDTH-1, frame_start=0.
  - Completed word = {shreg[WIDTH-2:0], ser_in}; bit_cnt wraps to 0.
- Output buffer FSM, two states:
  - EMPTY: par_valid=0. On completion: par_out <= word, go to FULL. Latency: par_valid rises the cycle after the last bit is sampled.
  - FULL: par_valid=1; par_out held stable.
    - par_ready=1, no completion: go to EMPTY.
    - par_ready=1 with completion: par_out <= new word, stay FULL (back-to-back, no bubble).
    - par_ready=0 with completion: new word dropped, par_out unchanged, overrun <= 1.
- overrun:
  - Sticky until clr_overrun or rst.
  - Set and clear in the same cycle: set wins.
- par_out is not cleared on consume; it retains the last word.
- Throughput: one word per WIDTH ser_en cycles. Consumer may stall up to WIDTH-1 cycles with no loss.

Test Plan:
- Reset, then 32 ser_en cycles shifting 0xA5A5_3C3C MSB first, par_ready=1 -> par_valid=1 for exactly 1 cycle, starting the cycle after bit 32; par_out=0xA5A5_3C3C; bit_cnt=0; overrun=0.
- Two back-to-back words 0x0000_0001 then 0xFFFF_FFFE, par_ready held 1 -> two valid handshakes 32 cycles apart, correct data, no gap cycles in shifting.
- Word 0x1234_5678 with par_ready=0, then 32 more bits of 0xDEAD_BEEF -> par_out stays 0x1234_5678; overrun=1 the cycle after bit 64; pulse clr_overrun -> overrun=0 next cycle.
- Word 0x1111_1111 with par_ready=0; assert par_ready exactly in the cycle the last bit of 0x2222_2222 is sampled -> par_valid stays 1; par_out=0x2222_2222; overrun=0.
- Shift 10 bits of junk, pulse frame_start with ser_en=1 on first bit of 0xCAFE_F00D -> bit_cnt=1 after the pulse; par_out=0xCAFE_F00D after 32 bits total from the frame_start cycle.
- Assert rst mid-word (bit_cnt=17) and while par_valid=1 -> next cycle bit_cnt=0, par_valid=0, par_out=0, overrun=0; a subsequent full word is received correctly.
